// File: rtl/mod_swapchain_if.sv
// Settings/sampler handshake for the segment-transition controller.
// master = settings decoder + sampler side, slave = mod_swapchain.
`timescale 1ns/1ps
interface mod_swapchain_if #(
  parameter int SYS_TIME_WIDTH = 64,
  parameter int GPIO_WIDTH     = 4
);
  logic                      update;
  logic                      req_rd_segment;
  logic [7:0]                transition_mode;
  logic [SYS_TIME_WIDTH-1:0] transition_value;
  logic [31:0]               rep0;
  logic [31:0]               rep1;
  logic [SYS_TIME_WIDTH-1:0] sys_time;
  logic                      loop_end;
  logic [GPIO_WIDTH-1:0]     gpio_in;
  logic                      segment;
  logic                      switched;
  logic                      stop;
  logic                      pending;

  modport master (
    output update, req_rd_segment, transition_mode, transition_value,
           rep0, rep1, sys_time, loop_end, gpio_in,
    input  segment, switched, stop, pending
  );

  modport slave (
    input  update, req_rd_segment, transition_mode, transition_value,
           rep0, rep1, sys_time, loop_end, gpio_in,
    output segment, switched, stop, pending
  );
endinterface

// File: rtl/mod_swapchain.sv
// Segment-transition controller: picks the buffer segment the modulation
// sampler reads, times segment switches and stops finite-repeat segments.
`timescale 1ns/1ps
module mod_swapchain #(
  parameter int SYS_TIME_WIDTH = 64,
  parameter int GPIO_WIDTH     = 4
) (
  input  logic            clk,
  input  logic            rst,
  mod_swapchain_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_SYNC = 2'd1,
    WAIT_TIME = 2'd2,
    WAIT_GPIO = 2'd3
  } state_t;

  localparam logic [7:0]  MODE_SYNC = 8'h00;
  localparam logic [7:0]  MODE_TIME = 8'h01;
  localparam logic [7:0]  MODE_GPIO = 8'h02;
  localparam logic [7:0]  MODE_IMM  = 8'hFF;
  localparam logic [31:0] REP_INF   = 32'hFFFF_FFFF;

  function automatic state_t wait_state(input logic [7:0] mode);
    state_t s;
    case (mode)
      MODE_SYNC: s = WAIT_SYNC;
      MODE_TIME: s = WAIT_TIME;
      MODE_GPIO: s = WAIT_GPIO;
      default:   s = RUN;
    endcase
    return s;
  endfunction

  function automatic logic gpio_rise(input logic [GPIO_WIDTH-1:0] now,
                                     input logic [GPIO_WIDTH-1:0] prev,
                                     input logic [1:0]            idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      if (i == int'(idx)) hit = now[i] & ~prev[i];
    end
    return hit;
  endfunction

  state_t                    state;
  logic                      segment_q;
  logic                      switched_q;
  logic                      stop_q;
  logic                      pending_q;
  logic [31:0]               loop_cnt;
  logic [31:0]               rep_active;
  logic [GPIO_WIDTH-1:0]     gpio_prev;
  logic                      req_seg_q;
  logic [SYS_TIME_WIDTH-1:0] value_q;

  logic mode_wait;
  logic mode_imm;
  logic take_update;
  logic wait_hit;
  logic do_switch;
  logic switch_seg;
  logic count_loop;

  always_comb begin
    mode_wait   = (bus.transition_mode == MODE_SYNC) ||
                  (bus.transition_mode == MODE_TIME) ||
                  (bus.transition_mode == MODE_GPIO);
    mode_imm    = (bus.transition_mode == MODE_IMM);
    take_update = bus.update && (mode_wait || mode_imm);

    // A stopped sampler never wraps, so a sync wait would otherwise hang.
    wait_hit = 1'b0;
    case (state)
      WAIT_SYNC: wait_hit = bus.loop_end || stop_q;
      WAIT_TIME: wait_hit = (bus.sys_time >= value_q);
      WAIT_GPIO: wait_hit = gpio_rise(bus.gpio_in, gpio_prev, value_q[1:0]);
      default:   wait_hit = 1'b0;
    endcase

    // A valid UPDATE always overrides whatever the old request was waiting on.
    do_switch  = (bus.update && mode_imm) || (!take_update && wait_hit);
    switch_seg = take_update ? bus.req_rd_segment : req_seg_q;
    count_loop = !do_switch && bus.loop_end && !stop_q && (rep_active != REP_INF);
  end

  // Request payload; only meaningful while a wait state is active.
  always_ff @(posedge clk) begin
    if (bus.update && mode_wait) begin
      req_seg_q <= bus.req_rd_segment;
      value_q   <= bus.transition_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      segment_q  <= 1'b0;
      switched_q <= 1'b0;
      stop_q     <= 1'b0;
      pending_q  <= 1'b0;
      loop_cnt   <= '0;
      rep_active <= REP_INF;
      gpio_prev  <= '0;
    end else begin
      gpio_prev  <= bus.gpio_in;
      switched_q <= do_switch;
      if (do_switch) begin
        segment_q  <= switch_seg;
        stop_q     <= 1'b0;
        loop_cnt   <= '0;
        rep_active <= switch_seg ? bus.rep1 : bus.rep0;
        pending_q  <= 1'b0;
        state      <= RUN;
      end else begin
        if (take_update) begin
          state     <= wait_state(bus.transition_mode);
          pending_q <= 1'b1;
        end
        if (count_loop) begin
          if (loop_cnt == rep_active) stop_q <= 1'b1;
          else                        loop_cnt <= loop_cnt + 32'd1;
        end
      end
    end
  end

  assign bus.segment  = segment_q;
  assign bus.switched = switched_q;
  assign bus.stop     = stop_q;
  assign bus.pending  = pending_q;

endmodule
